seeg_adc_spi_responder: RTL and testbench

Synthesizable SPI slave that emulates the multichannel sEEG ADC front-end on the far end of the seeg recording link. It decodes 16-bit commands (CONVERT / READ / WRITE) and returns each result two frames later, the way the real headstage does. Used in closed-loop sim and FPGA self-test in place of the real headstage. Channel data is a deterministic test pattern so the receiver can check it bit-exactly.

---
 rtl/seeg_adc_spi_responder.sv | 196 +++++++++++++++++++
 tb/tb_seeg_adc_spi_responder.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/seeg_adc_spi_responder.sv
// SPI mode-0 responder emulating the multichannel sEEG ADC headstage.
// Decodes 16-bit CONVERT / CALIBRATE / READ / WRITE commands and returns each
// result two frames later through a two-slot pipeline. SPI pins are
// oversampled by clk through synchronizers and edge detectors.
//
// Frame handshake: a frame begins on a synced cs_n fall (only once cs_n has
// been seen high since reset), mosi is captured on synced sclk rises, miso
// changes on synced sclk falls, and the frame ends on a synced cs_n rise.
// cmd_valid / frame_err are single-cycle strobes; cmd_word holds until the
// next accepted frame.
module seeg_adc_spi_responder #(
    parameter int         NUM_CH      = 32,
    parameter logic [7:0] CHIP_ID     = 8'h01,
    parameter int         SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cs_n,
    input  logic        sclk,
    input  logic        mosi,
    output logic        miso,
    output logic        cmd_valid,
    output logic [15:0] cmd_word,
    output logic        frame_err,
    output logic [9:0]  conv_count
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SHIFT     = 2'd1,
        ST_DONE_WAIT = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Sync chains reset low so a cs_n held low through reset is not mistaken
    // for a falling edge; armed_q only sets after a real high is observed.
    logic [SYNC_STAGES-1:0] cs_sync_q, sclk_sync_q, mosi_sync_q;
    logic        cs_prev_q, sclk_prev_q, armed_q;
    logic [3:0]  bit_cnt_q;
    logic [15:0] rx_q, tx_q;
    logic [15:0] slot0_q, slot1_q;
    logic [7:0]  regs_q [8];
    logic [9:0]  conv_count_q;
    logic [15:0] cmd_word_q;
    logic        cmd_valid_q, frame_err_q;

    logic cs_s, sclk_s, mosi_s;
    logic cs_fall, cs_rise, sclk_rise, sclk_fall;
    logic start_frame, shift_in, shift_out, clr_tx, frame_done, frame_abort;
    logic [15:0] result;
    logic [1:0]  op;
    logic [5:0]  addr;

    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign cs_fall   = cs_prev_q & ~cs_s;
    assign cs_rise   = ~cs_prev_q & cs_s;
    assign sclk_rise = ~sclk_prev_q & sclk_s;
    assign sclk_fall = sclk_prev_q & ~sclk_s;

    // Synchronize SPI pins, keep previous synced values for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cs_sync_q   <= '0;
            sclk_sync_q <= '0;
            mosi_sync_q <= '0;
            cs_prev_q   <= 1'b0;
            sclk_prev_q <= 1'b0;
            armed_q     <= 1'b0;
        end else begin
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_n};
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
            cs_prev_q   <= cs_s;
            sclk_prev_q <= sclk_s;
            if (cs_s) armed_q <= 1'b1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // FSM next-state logic; an early cs_n rise takes priority over the 16th sclk.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:      if (cs_fall && armed_q) state_d = ST_SHIFT;
            ST_SHIFT: begin
                if (cs_rise)                              state_d = ST_IDLE;
                else if (sclk_rise && bit_cnt_q == 4'd15) state_d = ST_DONE_WAIT;
            end
            ST_DONE_WAIT: if (cs_rise) state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    // FSM output decode: datapath strobes for the current state.
    always_comb begin
        start_frame = 1'b0;
        shift_in    = 1'b0;
        shift_out   = 1'b0;
        clr_tx      = 1'b0;
        frame_done  = 1'b0;
        frame_abort = 1'b0;
        case (state_q)
            ST_IDLE:  start_frame = cs_fall & armed_q;
            ST_SHIFT: begin
                if (cs_rise) begin
                    frame_abort = 1'b1;
                end else begin
                    shift_in  = sclk_rise;
                    shift_out = sclk_fall;
                end
            end
            ST_DONE_WAIT: begin
                if (cs_rise) frame_done = 1'b1;
                else         clr_tx     = sclk_fall;
            end
            default: ;
        endcase
    end

    // Command decode of the completed frame held in rx_q.
    assign op   = rx_q[15:14];
    assign addr = rx_q[13:8];

    always_comb begin
        result = 16'h0000;
        case (op)
            2'b00: if ({2'b00, addr} < 8'(NUM_CH)) result = {addr, conv_count_q};
            2'b01: result = 16'h0000;
            2'b10: begin
                if (addr < 6'd8)       result = {8'h00, regs_q[addr[2:0]]};
                else if (addr == 6'd63) result = {8'h00, CHIP_ID};
            end
            default: result = {8'hFF, rx_q[7:0]};
        endcase
    end

    // Shift registers: capture mosi on sclk rise, advance miso on sclk fall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt_q <= 4'd0;
            rx_q      <= 16'h0000;
            tx_q      <= 16'h0000;
        end else begin
            if (start_frame) begin
                tx_q      <= slot1_q;
                bit_cnt_q <= 4'd0;
            end else if (shift_out) begin
                tx_q <= {tx_q[14:0], 1'b0};
            end else if (clr_tx) begin
                tx_q <= 16'h0000;
            end
            if (shift_in) begin
                rx_q      <= {rx_q[14:0], mosi_s};
                bit_cnt_q <= bit_cnt_q + 4'd1;
            end
        end
    end

    // Frame-end execution: strobes, pipeline advance, register file, sweep counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_valid_q  <= 1'b0;
            frame_err_q  <= 1'b0;
            cmd_word_q   <= 16'h0000;
            slot0_q      <= 16'h0000;
            slot1_q      <= 16'h0000;
            conv_count_q <= 10'd0;
            for (int i = 0; i < 8; i++) regs_q[i] <= 8'h00;
        end else begin
            cmd_valid_q <= frame_done;
            frame_err_q <= frame_abort;
            if (frame_done) begin
                cmd_word_q <= rx_q;
                slot1_q    <= slot0_q;
                slot0_q    <= result;
                if (op == 2'b11 && addr < 6'd8) regs_q[addr[2:0]] <= rx_q[7:0];
                if (op == 2'b00 && addr == 6'd0) conv_count_q <= conv_count_q + 10'd1;
            end
        end
    end

    assign miso       = (state_q != ST_IDLE) & tx_q[15];
    assign cmd_valid  = cmd_valid_q;
    assign cmd_word   = cmd_word_q;
    assign frame_err  = frame_err_q;
    assign conv_count = conv_count_q;

endmodule

// File: tb/tb_seeg_adc_spi_responder.sv
// Directed bench for seeg_adc_spi_responder: drives SPI mode-0 frames from
// the master side and compares returned miso words and side outputs against
// hand-computed values.
`timescale 1ns/1ps
module tb_seeg_adc_spi_responder;

    localparam int HALF = 8;  // clk periods per sclk phase

    logic        clk, rst, cs_n, sclk, mosi;
    logic        miso, cmd_valid, frame_err;
    logic [15:0] cmd_word;
    logic [9:0]  conv_count;

    int n_cmp = 0;
    int n_err = 0;
    int cv_cnt = 0;
    int fe_cnt = 0;
    logic [15:0] rx;

    seeg_adc_spi_responder #(
        .NUM_CH(32), .CHIP_ID(8'h01), .SYNC_STAGES(2)
    ) dut (
        .clk(clk), .rst(rst), .cs_n(cs_n), .sclk(sclk), .mosi(mosi),
        .miso(miso), .cmd_valid(cmd_valid), .cmd_word(cmd_word),
        .frame_err(frame_err), .conv_count(conv_count)
    );

    // Clock and watchdog.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (got timeout, need finish)");
        $fatal(1);
    end

    // Strobe counters, sampled away from the active edge.
    always @(negedge clk) begin
        if (cmd_valid) cv_cnt++;
        if (frame_err) fe_cnt++;
    end

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One SPI frame of nbits clocks; rst_at >= 0 pulses reset during that bit.
    task automatic spi_frame(input logic [15:0] cmd, input int nbits, input int rst_at,
                             output logic [15:0] word);
        word = 16'h0000;
        @(negedge clk) cs_n = 1'b0;
        repeat (HALF) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            mosi = (i < 16) ? cmd[15-i] : 1'b1;
            if (i == rst_at) begin
                rst = 1'b1;
                repeat (3) @(negedge clk);
                rst = 1'b0;
                @(negedge clk);
                check_eq("rst_mid_miso", {15'd0, miso}, 16'h0000);
                check_eq("rst_mid_cmd_word", cmd_word, 16'h0000);
                check_eq("rst_mid_conv_count", {6'd0, conv_count}, 16'h0000);
            end
            repeat (HALF) @(negedge clk);
            if (i < 16) word[15-i] = miso;
            else        check_eq("miso_extra_bit", {15'd0, miso}, 16'h0000);
            sclk = 1'b1;
            repeat (HALF) @(negedge clk);
            sclk = 1'b0;
        end
        repeat (HALF) @(negedge clk);
        cs_n = 1'b1;
        repeat (3 * HALF) @(negedge clk);
        check_eq("miso_cs_high", {15'd0, miso}, 16'h0000);
    endtask

    task automatic run(input logic [15:0] cmd, input logic [15:0] exp, input string tag);
        logic [15:0] w;
        spi_frame(cmd, 16, -1, w);
        check_eq(tag, w, exp);
    endtask

    initial begin
        rst = 1'b1; cs_n = 1'b1; sclk = 1'b0; mosi = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        check_eq("reset_miso", {15'd0, miso}, 16'h0000);
        check_eq("reset_cmd_valid", {15'd0, cmd_valid}, 16'h0000);
        check_eq("reset_cmd_word", cmd_word, 16'h0000);
        check_eq("reset_frame_err", {15'd0, frame_err}, 16'h0000);
        check_eq("reset_conv_count", {6'd0, conv_count}, 16'h0000);

        // CONVERT sweep: ch1 result carries count 1 -> 0x0401 in frame 4.
        run(16'h0000, 16'h0000, "conv_f1");
        run(16'h0100, 16'h0000, "conv_f2");
        run(16'h0200, 16'h0000, "conv_f3");
        run(16'h0000, 16'h0401, "conv_f4");
        check_eq("conv_count_2", {6'd0, conv_count}, 16'd2);
        check_eq("cmd_valid_4", 16'(cv_cnt), 16'd4);
        check_eq("cmd_word_conv", cmd_word, 16'h0000);

        // WRITE / READ / CHIP_ID; first two return the ch2 and ch0 patterns.
        run(16'hC3A5, 16'h0801, "wr_r3");
        run(16'h8300, 16'h0001, "rd_r3");
        run(16'hBF00, 16'hFFA5, "rd_r63");
        run(16'h4000, 16'h00A5, "cal_a");
        run(16'h4000, 16'h0001, "cal_b");
        check_eq("cmd_word_cal", cmd_word, 16'h4000);

        // Out-of-range channel.
        run(16'h2800, 16'h0000, "conv_ch40");
        run(16'h4000, 16'h0000, "cal_c");
        run(16'h4000, 16'h0000, "ch40_result");
        check_eq("conv_count_ch40", {6'd0, conv_count}, 16'd2);

        // Short frame between two CONVERTs.
        run(16'h0300, 16'h0000, "conv_ch3");
        spi_frame(16'h0500, 9, -1, rx);
        check_eq("short_frame_err", 16'(fe_cnt), 16'd1);
        check_eq("short_no_valid", 16'(cv_cnt), 16'd13);
        run(16'h0400, 16'h0000, "conv_ch4");
        run(16'h4000, 16'h0C02, "ch3_result");
        run(16'h4000, 16'h1002, "ch4_result");

        // Reset in the middle of a frame; slot1 holds 0xFF5A beforehand.
        run(16'hC55A, 16'h0000, "wr_r5");
        run(16'hC177, 16'h0000, "wr_r1");
        spi_frame(16'h8500, 16, 7, rx);
        check_eq("rst_partial_word", rx, 16'hFE00);
        check_eq("rst_no_valid", 16'(cv_cnt), 16'd18);
        check_eq("rst_no_err", 16'(fe_cnt), 16'd1);
        run(16'h0700, 16'h0000, "post_rst_f1");
        run(16'h0000, 16'h0000, "post_rst_f2");
        run(16'h4000, 16'h1C00, "post_rst_ch7");
        check_eq("post_rst_conv_count", {6'd0, conv_count}, 16'd1);

        // Over-long frame: 20 clocks, extra bits ignored, command executed.
        run(16'hC6FF, 16'h0000, "wr_r6");
        run(16'h4000, 16'h0000, "cal_d");
        spi_frame(16'h8600, 20, -1, rx);
        check_eq("long_frame_word", rx, 16'hFFFF);
        check_eq("long_cmd_word", cmd_word, 16'h8600);
        check_eq("long_no_err", 16'(fe_cnt), 16'd1);
        run(16'h4000, 16'h0000, "cal_e");
        run(16'h4000, 16'h00FF, "rd_r6_result");
        check_eq("final_cmd_valid", 16'(cv_cnt), 16'd26);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
